cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) between the two result producers, alu and LSB.
- Each producer gets a small per-source result queue. One result per cycle goes out on a registered CDB to ROB and RS.
- Producers are back-pressured with stall lines, and all queues are flushed on roll (branch misprediction rollback).
- Replaces the point-to-point ALU→ROB/RS and LSB→ROB/RS result wires.

Parameters:
- ROB_IDX_W, 4: width of the ROB index; must match `ROB_INDEX_RANGE.
- DEPTH, 2: entries per source queue, ≥2, power of two.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- roll  in  1  ROB rollback; flushes all queued results
- ALU_flag  in  1  alu result valid this cycle
- ALU_ROB_idx  in  ROB_IDX_W  destination ROB entry
- ALU_val  in  32  result value
- ALU_jump_flag  in  1  branch/jump outcome taken
- ALU_jump_PC  in  32  jump target
- ALU_stall  out  1  alu must not issue a new result next cycle
- LSB_flag  in  1  load result valid this cycle
- LSB_ROB_idx  in  ROB_IDX_W  destination ROB entry
- LSB_val  in  32  loaded value
- LSB_stall  out  1  LSB must not return a new result next cycle
- CDB_flag  out  1  broadcast valid
- CDB_src  out  1  0 = ALU, 1 = LSB
- CDB_ROB_idx  out  ROB_IDX_W  broadcast ROB entry
- CDB_val  out  32  broadcast value
- CDB_jump_flag  out  1  jump taken; forced 0 when CDB_src = 1
- CDB_jump_PC  out  32  jump target; 0 when CDB_src = 1
- ovf_err  out  1  sticky: a push arrived while its queue was full

Behaviour:
- Reset (rst = 1 at a clk edge): both queues empty, round-robin pointer = ALU, all outputs 0 (ovf_err included).
- rdy = 0:
  - No state changes; pushes in that cycle are ignored.
  - Outputs hold their previous value.
  - rdy overrides roll.
- Push: on a clk edge with rdy = 1 and roll = 0, an asserted X_flag writes {idx, val, jump_flag, jump_PC} into queue X. The LSB entry stores jump fields as 0.
- Push while queue X is full (count == DEPTH and no pop of X in the same cycle):
  - Entry is dropped.
  - ovf_err is set and stays 1 until rst.
- Stall: X_stall = (count_X ≥ DEPTH−1), combinational from registered counts. Count does not include a same-cycle push.
- Arbitration, each edge with rdy = 1 and roll = 0:
  - Only one queue non-empty: pop its head.
  - Both non-empty: pop the queue not granted last. The pointer then records the granted source.
  - Both empty: CDB_flag ← 0 and the pointer is unchanged.
- Registered CDB:
  - The popped entry drives CDB_* from the next cycle onward, with CDB_flag = 1 for exactly that one cycle unless another pop follows.
  - Latency: a push into an empty queue in cycle t appears on the CDB in cycle t+1 at the earliest.
  - Results never bypass the queue.
- Simultaneous push and pop of the same queue: both take effect and the count is unchanged. This is legal even when full.
- Ordering: FIFO order is kept within each source. There is no ordering guarantee between sources.
- roll = 1 (with rdy = 1):
  - Both queues cleared, pointer ← ALU.
  - CDB_flag ← 0 at that edge; pushes in the same cycle are discarded.
  - ovf_err is unaffected.
- Pointer wrap: read and write pointers are log2(DEPTH) bits with natural wrap; counts are log2(DEPTH)+1 bits.

Decomposition:
- Shared define.v holds:
  - `ROB_INDEX_RANGE
  - `CDB_SRC_ALU = 1'b0 and `CDB_SRC_LSB = 1'b1
  - `CDB_ENTRY_W = ROB_IDX_W+1+32+32
- One sub-module, cdb_fifo: synchronous FIFO with push/pop/flush, count, empty and full outputs, and DEPTH/width parameters. It is instantiated twice (ALU, LSB).
- Arbitration, stall and output registers live in cdb_arbiter.

Test Plan:
1. Reset, then one ALU push {idx=3, val=0x11, jump=1, PC=0x100} in cycle 5 → cycle 6: CDB_flag=1, src=0, idx=3, val=0x11, jump_flag=1, PC=0x100. Cycle 7: CDB_flag=0.
2. ALU and LSB push together every cycle for 4 cycles, ALU idx 1..4 and LSB idx 9..12 → CDB alternates: ALU1, LSB9, ALU2, LSB10, … Each source stays in order, and ALU_stall/LSB_stall assert once count reaches 1.
3. With DEPTH=2, hold the LSB queue full and push a third LSB result with no pop → entry dropped, ovf_err=1 and stays 1. The queue still contains the first two entries in order.
4. Two entries queued per source, assert roll for one cycle together with a new ALU push → next cycle CDB_flag=0 and stalls=0. The next push appears alone at t+1 with src=0.
5. rdy low for 3 cycles mid-stream with pushes asserted → CDB outputs hold, counts unchanged, pushes ignored. When rdy returns high, the sequence resumes exactly where it stopped.
6. LSB push {idx=7, val=0xDEADBEEF} → CDB src=1, jump_flag=0, jump_PC=0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter.
//   cdb_src_e     : CDB source encoding (ALU = 0, LSB = 1)
//   ROB_INDEX_W   : default ROB index width used across the core
//   cdb_entry_w() : width of one queued result {rob_idx, val, jump_flag, jump_pc}
package cdb_arbiter_pkg;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } cdb_src_e;

   localparam int ROB_INDEX_W = 4;

   function automatic int cdb_entry_w(input int rob_idx_w);
      return rob_idx_w + 1 + 32 + 32;
   endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Small synchronous result queue used once per CDB producer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : global ready; when low the queue is frozen
//   flush         : empties the queue (wins over push/pop)
//   push, din     : enqueue request and data; dropped when full unless popping
//   pop           : dequeue request; ignored when empty
//   dout          : head entry (valid while !empty)
//   count         : number of entries held
//   empty, full   : status derived from count
module cdb_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = cdb_entry_w(ROB_INDEX_W)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign dout    = mem[rd_ptr];

   // A full queue still accepts a push when its head leaves in the same cycle.
   assign do_pop  = en && !flush && pop && !empty;
   assign do_push = en && !flush && push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (en && flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates the single common data bus between the ALU and the LSB.
// Each producer feeds its own result queue; one queued result per cycle is
// broadcast on the registered CDB_* outputs to the ROB and the RS.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rdy                 : global ready; low freezes every register (beats roll)
//   roll                : rollback; flushes both queues and drops this cycle's pushes
//   ALU_*               : ALU result push {flag, ROB_idx, val, jump_flag, jump_PC}
//   ALU_stall           : ALU must not issue next cycle
//   LSB_*               : LSB result push {flag, ROB_idx, val}
//   LSB_stall           : LSB must not return next cycle
//   CDB_*               : registered broadcast; CDB_src 0 = ALU, 1 = LSB
//   ovf_err             : sticky, a push was dropped on a full queue
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int ROB_IDX_W = ROB_INDEX_W,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 roll,
   input  logic                 ALU_flag,
   input  logic [ROB_IDX_W-1:0] ALU_ROB_idx,
   input  logic [31:0]          ALU_val,
   input  logic                 ALU_jump_flag,
   input  logic [31:0]          ALU_jump_PC,
   output logic                 ALU_stall,
   input  logic                 LSB_flag,
   input  logic [ROB_IDX_W-1:0] LSB_ROB_idx,
   input  logic [31:0]          LSB_val,
   output logic                 LSB_stall,
   output logic                 CDB_flag,
   output logic                 CDB_src,
   output logic [ROB_IDX_W-1:0] CDB_ROB_idx,
   output logic [31:0]          CDB_val,
   output logic                 CDB_jump_flag,
   output logic [31:0]          CDB_jump_PC,
   output logic                 ovf_err
);

   localparam int ENTRY_W = cdb_entry_w(ROB_IDX_W);
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic [ENTRY_W-1:0] alu_din;
   logic [ENTRY_W-1:0] lsb_din;
   logic [ENTRY_W-1:0] alu_head;
   logic [ENTRY_W-1:0] lsb_head;
   logic [CNT_W-1:0]   alu_count;
   logic [CNT_W-1:0]   lsb_count;
   logic               alu_empty;
   logic               alu_full;
   logic               lsb_empty;
   logic               lsb_full;
   logic               pop_alu;
   logic               pop_lsb;
   logic               ovf_now;
   cdb_src_e           prio;

   // LSB results never carry a jump, so the jump fields are stored as zero.
   assign alu_din = {ALU_ROB_idx, ALU_val, ALU_jump_flag, ALU_jump_PC};
   assign lsb_din = {LSB_ROB_idx, LSB_val, 1'b0, 32'd0};

   cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_q (
      .clk   (clk),
      .rst   (rst),
      .en    (rdy),
      .flush (roll),
      .push  (ALU_flag),
      .pop   (pop_alu),
      .din   (alu_din),
      .dout  (alu_head),
      .count (alu_count),
      .empty (alu_empty),
      .full  (alu_full)
   );

   cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_lsb_q (
      .clk   (clk),
      .rst   (rst),
      .en    (rdy),
      .flush (roll),
      .push  (LSB_flag),
      .pop   (pop_lsb),
      .din   (lsb_din),
      .dout  (lsb_head),
      .count (lsb_count),
      .empty (lsb_empty),
      .full  (lsb_full)
   );

   // prio names the source that wins a tie; after every grant it moves to
   // the other source, so a tie always goes to the one not granted last.
   always_comb begin
      pop_alu = 1'b0;
      pop_lsb = 1'b0;
      if (!alu_empty && (lsb_empty || prio == SRC_ALU)) begin
         pop_alu = 1'b1;
      end else if (!lsb_empty) begin
         pop_lsb = 1'b1;
      end
   end

   // Stall looks only at registered counts; a same-cycle push is not counted.
   assign ALU_stall = (alu_count >= CNT_W'(DEPTH - 1));
   assign LSB_stall = (lsb_count >= CNT_W'(DEPTH - 1));

   assign ovf_now = (ALU_flag && alu_full && !pop_alu) ||
                    (LSB_flag && lsb_full && !pop_lsb);

   always_ff @(posedge clk) begin
      if (rst) begin
         prio          <= SRC_ALU;
         CDB_flag      <= 1'b0;
         CDB_src       <= 1'b0;
         CDB_ROB_idx   <= '0;
         CDB_val       <= '0;
         CDB_jump_flag <= 1'b0;
         CDB_jump_PC   <= '0;
         ovf_err       <= 1'b0;
      end else if (rdy) begin
         if (roll) begin
            prio     <= SRC_ALU;
            CDB_flag <= 1'b0;
         end else begin
            if (ovf_now) ovf_err <= 1'b1;
            if (pop_alu || pop_lsb) begin
               CDB_flag <= 1'b1;
               CDB_src  <= pop_lsb;
               {CDB_ROB_idx, CDB_val, CDB_jump_flag, CDB_jump_PC} <= pop_lsb ? lsb_head : alu_head;
               prio     <= pop_lsb ? SRC_ALU : SRC_LSB;
            end else begin
               CDB_flag <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, rdy, roll;
   logic        ALU_flag, ALU_jump_flag, ALU_stall;
   logic [3:0]  ALU_ROB_idx;
   logic [31:0] ALU_val, ALU_jump_PC;
   logic        LSB_flag, LSB_stall;
   logic [3:0]  LSB_ROB_idx;
   logic [31:0] LSB_val;
   logic        CDB_flag, CDB_src, CDB_jump_flag, ovf_err;
   logic [3:0]  CDB_ROB_idx;
   logic [31:0] CDB_val, CDB_jump_PC;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.ROB_IDX_W(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .roll(roll),
      .ALU_flag(ALU_flag), .ALU_ROB_idx(ALU_ROB_idx), .ALU_val(ALU_val),
      .ALU_jump_flag(ALU_jump_flag), .ALU_jump_PC(ALU_jump_PC), .ALU_stall(ALU_stall),
      .LSB_flag(LSB_flag), .LSB_ROB_idx(LSB_ROB_idx), .LSB_val(LSB_val), .LSB_stall(LSB_stall),
      .CDB_flag(CDB_flag), .CDB_src(CDB_src), .CDB_ROB_idx(CDB_ROB_idx), .CDB_val(CDB_val),
      .CDB_jump_flag(CDB_jump_flag), .CDB_jump_PC(CDB_jump_PC), .ovf_err(ovf_err)
   );

   typedef struct {
      bit        rst, rdy, roll;
      bit        af;
      bit [3:0]  ai;
      bit [31:0] av;
      bit        aj;
      bit [31:0] ap;
      bit        lf;
      bit [3:0]  li;
      bit [31:0] lv;
   } in_t;

   typedef struct {
      in_t       i;
      bit [70:0] e_cdb;
      bit [1:0]  e_stall;
      bit        e_ovf;
   } vec_t;

   typedef struct {
      bit [3:0]  idx;
      bit [31:0] val;
      bit        jf;
      bit [31:0] pc;
   } ent_t;

   // Reference model: one queue per source, a tie-break turn, the last broadcast.
   ent_t      mq_a[$];
   ent_t      mq_l[$];
   int        m_turn;
   bit [70:0] m_cdb;
   bit        m_ovf;
   vec_t      vt[$];

   function automatic in_t mk(bit af, bit [3:0] ai, bit [31:0] av, bit aj, bit [31:0] ap,
                              bit lf, bit [3:0] li, bit [31:0] lv);
      in_t x;
      x.rst = 1'b0; x.rdy = 1'b1; x.roll = 1'b0;
      x.af = af; x.ai = ai; x.av = av; x.aj = aj; x.ap = ap;
      x.lf = lf; x.li = li; x.lv = lv;
      return x;
   endfunction

   function automatic bit [70:0] cv(bit f, bit s, bit [3:0] i, bit [31:0] v, bit j, bit [31:0] p);
      return {f, s, i, v, j, p};
   endfunction

   function automatic bit [70:0] dut_cdb();
      return {CDB_flag, CDB_src, CDB_ROB_idx, CDB_val, CDB_jump_flag, CDB_jump_PC};
   endfunction

   task automatic add(input in_t i, input bit [70:0] c, input bit [1:0] s, input bit o);
      vec_t v;
      v.i = i; v.e_cdb = c; v.e_stall = s; v.e_ovf = o;
      vt.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic model_step(input in_t x);
      ent_t e;
      int   g;
      e = '{default: '0};
      if (x.rst) begin
         mq_a.delete(); mq_l.delete();
         m_turn = 0; m_cdb = '0; m_ovf = 1'b0;
      end else if (x.rdy) begin
         if (x.roll) begin
            mq_a.delete(); mq_l.delete();
            m_turn = 0; m_cdb[70] = 1'b0;
         end else begin
            g = -1;
            if (mq_a.size() > 0 && mq_l.size() > 0) g = m_turn;
            else if (mq_a.size() > 0)               g = 0;
            else if (mq_l.size() > 0)               g = 1;
            if (g == 0) e = mq_a.pop_front();
            if (g == 1) e = mq_l.pop_front();
            if (g >= 0) begin
               m_cdb  = {1'b1, g[0], e.idx, e.val, e.jf, e.pc};
               m_turn = 1 - g;
            end else begin
               m_cdb[70] = 1'b0;
            end
            if (x.af) begin
               if (mq_a.size() < DEPTH) mq_a.push_back('{x.ai, x.av, x.aj, x.ap});
               else m_ovf = 1'b1;
            end
            if (x.lf) begin
               if (mq_l.size() < DEPTH) mq_l.push_back('{x.li, x.lv, 1'b0, 32'd0});
               else m_ovf = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input in_t x);
      rst = x.rst; rdy = x.rdy; roll = x.roll;
      ALU_flag = x.af; ALU_ROB_idx = x.ai; ALU_val = x.av;
      ALU_jump_flag = x.aj; ALU_jump_PC = x.ap;
      LSB_flag = x.lf; LSB_ROB_idx = x.li; LSB_val = x.lv;
      @(posedge clk);
      model_step(x);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_cdb"}, {57'd0, dut_cdb()}, {57'd0, m_cdb});
      chk({tag, "_stall"}, {126'd0, ALU_stall, LSB_stall},
          {126'd0, (mq_a.size() >= DEPTH - 1), (mq_l.size() >= DEPTH - 1)});
      chk({tag, "_ovf"}, {127'd0, ovf_err}, {127'd0, m_ovf});
   endtask

   in_t I, R, x;
   int  lsb_seen[$];

   initial begin
      I = mk(0, 0, 0, 0, 0, 0, 0, 0);
      R = I; R.rst = 1'b1;

      // Directed table: single ALU/LSB results, then paired pushes with alternation
      // and an LSB drop when its queue is full, finishing with a reset.
      add(R, cv(0,0,0,0,0,0), 2'b00, 0);
      add(I, cv(0,0,0,0,0,0), 2'b00, 0);
      add(mk(1,3,'h11,1,'h100, 0,0,0), cv(0,0,0,0,0,0), 2'b10, 0);
      add(I, cv(1,0,3,'h11,1,'h100), 2'b00, 0);
      add(I, cv(0,0,3,'h11,1,'h100), 2'b00, 0);
      add(mk(0,0,0,0,0, 1,7,'hDEADBEEF), cv(0,0,3,'h11,1,'h100), 2'b01, 0);
      add(I, cv(1,1,7,'hDEADBEEF,0,0), 2'b00, 0);
      add(mk(1,1,'hA1,0,0, 1,9,'hB9),     cv(0,1,7,'hDEADBEEF,0,0), 2'b11, 0);
      add(mk(1,2,'hA2,1,'h204, 1,10,'hBA), cv(1,0,1,'hA1,0,0), 2'b11, 0);
      add(mk(1,3,'hA3,0,0, 1,11,'hBB),    cv(1,1,9,'hB9,0,0), 2'b11, 0);
      add(mk(1,4,'hA4,0,0, 1,12,'hBC),    cv(1,0,2,'hA2,1,'h204), 2'b11, 1);
      add(I, cv(1,1,10,'hBA,0,0), 2'b11, 1);
      add(I, cv(1,0,3,'hA3,0,0), 2'b11, 1);
      add(I, cv(1,1,11,'hBB,0,0), 2'b10, 1);
      add(I, cv(1,0,4,'hA4,0,0), 2'b00, 1);
      add(I, cv(0,0,4,'hA4,0,0), 2'b00, 1);
      add(R, cv(0,0,0,0,0,0), 2'b00, 0);

      foreach (vt[k]) begin
         step(vt[k].i);
         chk($sformatf("tbl%0d_cdb", k),   {57'd0, dut_cdb()},           {57'd0, vt[k].e_cdb});
         chk($sformatf("tbl%0d_stall", k), {126'd0, ALU_stall, LSB_stall}, {126'd0, vt[k].e_stall});
         chk($sformatf("tbl%0d_ovf", k),   {127'd0, ovf_err},             {127'd0, vt[k].e_ovf});
      end

      // Overflow: LSB full while the ALU wins the tie; the dropped entry never appears.
      step(R);
      step(mk(1,1,'h1,0,0, 1,1,'h51)); check_model("ovf_a");
      step(mk(1,2,'h2,0,0, 1,2,'h52)); check_model("ovf_b");
      step(mk(1,3,'h3,0,0, 1,3,'h53)); check_model("ovf_c");
      step(mk(0,0,0,0,0,   1,4,'h54)); check_model("ovf_d");
      chk("ovf_set", {127'd0, ovf_err}, 128'd1);
      for (int n = 0; n < 5; n++) begin
         step(I); check_model("ovf_drain");
         if (CDB_flag && CDB_src) lsb_seen.push_back(int'(CDB_ROB_idx));
      end
      chk("ovf_lsb_cnt", 128'(lsb_seen.size()), 128'd2);
      if (lsb_seen.size() == 2)
         chk("ovf_lsb_order", {120'd0, 4'(lsb_seen[0]), 4'(lsb_seen[1])}, {120'd0, 8'h23});
      chk("ovf_sticky", {127'd0, ovf_err}, 128'd1);

      // Roll with two entries per source and a concurrent ALU push.
      step(R);
      step(mk(1,1,'h61,0,0, 1,9,'h71));
      step(mk(1,2,'h62,0,0, 1,10,'h72));
      step(mk(1,3,'h63,0,0, 1,11,'h73)); check_model("pre_roll");
      x = mk(1,5,'h65,0,0, 0,0,0); x.roll = 1'b1;
      step(x);
      chk("roll_flag",  {127'd0, CDB_flag}, 128'd0);
      chk("roll_stall", {126'd0, ALU_stall, LSB_stall}, 128'd0);
      check_model("roll");
      step(mk(1,6,'h66,1,'h300, 0,0,0));
      chk("roll_nobypass", {127'd0, CDB_flag}, 128'd0);
      step(I);
      chk("roll_next", {122'd0, CDB_flag, CDB_src, CDB_ROB_idx}, {122'd0, 1'b1, 1'b0, 4'd6});
      check_model("post_roll");

      // rdy low for three cycles with pushes pending; roll is also ignored while frozen.
      step(R);
      step(mk(1,1,'h81,0,0, 1,9,'h91));
      step(mk(1,2,'h82,0,0, 1,10,'h92)); check_model("pre_frz");
      for (int n = 0; n < 3; n++) begin
         x = mk(1,7,'h87,0,0, 1,8,'h98); x.rdy = 1'b0; x.roll = (n == 1);
         step(x);
         chk("frz_hold", {122'd0, CDB_flag, CDB_src, CDB_ROB_idx}, {122'd0, 1'b1, 1'b0, 4'd1});
         check_model("frz");
      end
      step(I);
      chk("resume", {122'd0, CDB_flag, CDB_src, CDB_ROB_idx}, {122'd0, 1'b1, 1'b1, 4'd9});
      check_model("resume");
      for (int n = 0; n < 4; n++) begin
         step(I); check_model("drain");
      end

      // Random traffic against the model.
      step(R);
      for (int n = 0; n < 600; n++) begin
         x.rst  = ($urandom_range(0, 299) == 0);
         x.rdy  = ($urandom_range(0, 7) != 0);
         x.roll = ($urandom_range(0, 24) == 0);
         x.af   = $urandom_range(0, 1) == 1;
         x.ai   = 4'($urandom_range(0, 15));
         x.av   = $urandom;
         x.aj   = $urandom_range(0, 1) == 1;
         x.ap   = $urandom;
         x.lf   = $urandom_range(0, 1) == 1;
         x.li   = 4'($urandom_range(0, 15));
         x.lv   = $urandom;
         step(x);
         check_model("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
